// File: rtl/fuzzy_wavelet_bank.sv
// Multi-level Haar wavelet decomposition engine. Samples arrive on an asynchronous strobe
// and cascade through LEVELS approx/detail stages; one channel is muxed onto the output bus.
module fuzzy_wavelet_bank #(
  parameter int DATA_W = 8,
  parameter int LEVELS = 4,
  parameter int SEL_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_data_clk,
  input  logic [DATA_W-1:0] i_value,
  input  logic [SEL_W-1:0]  i_select_output_channel,
  output logic [DATA_W-1:0] o_multiplexed_wavelet_out,
  output logic              o_active
);

  localparam int NCH = LEVELS + 2;
  localparam logic [DATA_W-1:0] MSB_FLIP = {1'b1, {(DATA_W-1){1'b0}}};

  logic [1:0]        rst_sync_q;
  logic              rst_int_n;
  logic              sync1_q, sync2_q, prev_q, stb_q, stb_d, raw_upd_q;
  logic [DATA_W-1:0] val1_q, val2_q, raw_q;
  logic [DATA_W-1:0] out_q, out_d;
  logic              act_q, act_d;

  // index 0 is the capture front end; index k is stage k
  logic [DATA_W-1:0] approx_w [LEVELS+1];
  logic [DATA_W-1:0] detail_w [LEVELS+1];
  logic              valid_w  [LEVELS+1];
  logic [DATA_W-1:0] chan_w   [NCH];
  logic              upd_w    [NCH];

  // reset asserts asynchronously but releases on a clock edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_int_n = rst_sync_q[1];

  assign stb_d = sync2_q & ~prev_q;

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      prev_q    <= 1'b0;
      stb_q     <= 1'b0;
      val1_q    <= '0;
      val2_q    <= '0;
      raw_q     <= '0;
      raw_upd_q <= 1'b0;
    end else begin
      sync1_q   <= i_data_clk;
      sync2_q   <= sync1_q;
      prev_q    <= sync2_q;
      stb_q     <= stb_d;
      val1_q    <= i_value;
      val2_q    <= val1_q;
      raw_upd_q <= stb_q;
      if (stb_q) raw_q <= val2_q;
    end
  end

  assign approx_w[0] = val2_q;
  assign detail_w[0] = '0;
  assign valid_w[0]  = stb_q;

  for (genvar k = 1; k <= LEVELS; k++) begin : g_stage
    logic [DATA_W-1:0] a_q, apx_q, det_q;
    logic              ph_q, vld_q;
    logic [DATA_W:0]   sum_w, diff_w;
    logic [DATA_W-1:0] in_w;
    logic              in_stb_w;

    assign in_w     = approx_w[k-1];
    assign in_stb_w = valid_w[k-1];
    assign sum_w    = {1'b0, a_q} + {1'b0, in_w};
    assign diff_w   = {1'b0, a_q} - {1'b0, in_w};

    always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
        a_q   <= '0;
        apx_q <= '0;
        det_q <= '0;
        ph_q  <= 1'b0;
        vld_q <= 1'b0;
      end else begin
        vld_q <= 1'b0;
        if (in_stb_w) begin
          if (!ph_q) begin
            a_q  <= in_w;
            ph_q <= 1'b1;
          end else begin
            apx_q <= DATA_W'(sum_w >> 1);
            // signed floor-halved difference stored as offset binary
            det_q <= DATA_W'($signed(diff_w) >>> 1) ^ MSB_FLIP;
            ph_q  <= 1'b0;
            vld_q <= 1'b1;
          end
        end
      end
    end

    assign approx_w[k] = apx_q;
    assign detail_w[k] = det_q;
    assign valid_w[k]  = vld_q;
    assign chan_w[k]   = det_q;
    assign upd_w[k]    = vld_q;
  end

  assign chan_w[0]     = raw_q;
  assign upd_w[0]      = raw_upd_q;
  assign chan_w[NCH-1] = approx_w[LEVELS];
  assign upd_w[NCH-1]  = valid_w[LEVELS];

  always_comb begin
    out_d = '0;
    act_d = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (i_select_output_channel == SEL_W'(i)) begin
        out_d = chan_w[i];
        act_d = upd_w[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      out_q <= '0;
      act_q <= 1'b0;
    end else begin
      out_q <= out_d;
      act_q <= act_d;
    end
  end

  assign o_multiplexed_wavelet_out = out_q;
  assign o_active                  = act_q;

endmodule

// File: tb/tb_fuzzy_wavelet_bank.sv
// Bench for fuzzy_wavelet_bank: directed and random sample streams compared against an
// arithmetic pairwise Haar model of the channel values and of the o_active pulse count.
module tb_fuzzy_wavelet_bank;
  localparam int L = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_data_clk = 1'b0;
  logic [7:0] i_value = 8'd0;
  logic [7:0] sel = 8'd0;
  logic [7:0] o_out;
  logic       o_active;

  fuzzy_wavelet_bank #(.DATA_W(8), .LEVELS(L), .SEL_W(8)) dut (
    .clk                       (clk),
    .rst_n                     (rst_n),
    .i_data_clk                (i_data_clk),
    .i_value                   (i_value),
    .i_select_output_channel   (sel),
    .o_multiplexed_wavelet_out (o_out),
    .o_active                  (o_active)
  );

  always #5 clk = ~clk;

  int act_cnt = 0;
  always @(negedge clk) if (o_active === 1'b1) act_cnt = act_cnt + 1;

  int checks = 0;
  int errors = 0;
  int exp_ch [L+2];
  bit exp_upd[L+2];
  bit pend   [L+1];
  int pa     [L+1];
  int exp_act = 0;
  int snap;
  int n;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < L+2; i++) exp_ch[i] = 0;
    for (int k = 0; k <= L; k++) pend[k] = 1'b0;
  endtask

  // one sample enters a tree of pairwise averages/differences
  task automatic model_push(input int v);
    int cur, d;
    bit carry;
    for (int i = 0; i < L+2; i++) exp_upd[i] = 1'b0;
    exp_ch[0] = v; exp_upd[0] = 1'b1;
    cur = v; carry = 1'b1;
    for (int k = 1; k <= L; k++) begin
      if (carry) begin
        if (!pend[k]) begin
          pend[k] = 1'b1; pa[k] = cur; carry = 1'b0;
        end else begin
          pend[k] = 1'b0;
          d = pa[k] - cur;
          exp_ch[k] = ((d >= 0) ? d / 2 : -((1 - d) / 2)) + 128;
          exp_upd[k] = 1'b1;
          cur = (pa[k] + cur) / 2;
          if (k == L) begin exp_ch[L+1] = cur; exp_upd[L+1] = 1'b1; end
        end
      end
    end
    if (int'(sel) <= L+1 && exp_upd[sel]) exp_act++;
  endtask

  function automatic int exp_out();
    return (int'(sel) <= L+1) ? exp_ch[sel] : 0;
  endfunction

  task automatic send(input int v, input int gap);
    @(negedge clk);
    i_value = 8'(v);
    i_data_clk = 1'b1;
    repeat (2) @(negedge clk);
    i_data_clk = 1'b0;
    repeat (gap - 2) @(negedge clk);
    model_push(v);
  endtask

  task automatic send_chk(input int v, input string tag);
    send(v, 10);
    chk({tag, "_out"}, 32'(o_out), 32'(exp_out()));
    chk({tag, "_act"}, 32'(act_cnt), 32'(exp_act));
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out", 32'(o_out), 0);
    chk("rst_act", 32'(o_active), 0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    chk("por_out", 32'(o_out), 0);
    chk("por_act", 32'(o_active), 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    sel = 8'd1;
    send_chk(10, "l1_a");
    send_chk(4,  "l1_pos");
    chk("l1_pos_const", 32'(o_out), 131);
    send_chk(4,  "l1_b");
    send_chk(10, "l1_neg");
    chk("l1_neg_const", 32'(o_out), 125);

    // reset in the middle of a pair
    send_chk(77, "mid");
    do_reset();
    send_chk(10, "post_a");
    send_chk(4,  "post_b");
    chk("post_const", 32'(o_out), 131);

    sel = 8'd2;
    send_chk(20, "cas_a");
    send_chk(30, "cas_b");
    chk("cas_const", 32'(o_out), 119);

    // select change alone
    snap = act_cnt;
    @(negedge clk); sel = 8'd0;
    @(negedge clk); @(negedge clk);
    chk("selchg_out", 32'(o_out), 30);
    chk("selchg_act", 32'(act_cnt - snap), 0);

    sel = 8'd1;
    send_chk(255, "ext_a"); send_chk(0, "ext_b");
    chk("ext_pos", 32'(o_out), 255);
    send_chk(0, "ext_c"); send_chk(255, "ext_d");
    chk("ext_neg", 32'(o_out), 0);

    for (int i = 0; i < 40; i++) begin
      n = $urandom_range(0, 7);
      sel = (n == 7) ? 8'($urandom_range(6, 255)) : 8'(n);
      send_chk($urandom_range(0, 255), "rnd");
    end

    // out-of-range selects over 16 fast strobes
    sel = 8'd6; snap = act_cnt;
    for (int i = 0; i < 16; i++) send($urandom_range(1, 255), 4);
    repeat (10) @(negedge clk);
    chk("oor6_out", 32'(o_out), 0);
    chk("oor6_act", 32'(act_cnt - snap), 0);
    sel = 8'd255; snap = act_cnt;
    for (int i = 0; i < 16; i++) send($urandom_range(1, 255), 4);
    repeat (10) @(negedge clk);
    chk("oor255_out", 32'(o_out), 0);
    chk("oor255_act", 32'(act_cnt - snap), 0);

    // saturated input through the approximation path
    do_reset();
    sel = 8'd5;
    for (int i = 0; i < 16; i++) send(255, 4);
    repeat (10) @(negedge clk);
    chk("sat_apx", 32'(o_out), 255);
    chk("sat_apx_model", 32'(o_out), 32'(exp_out()));
    @(negedge clk); sel = 8'd2;
    repeat (2) @(negedge clk);
    chk("sat_det", 32'(o_out), 128);

    // strobe throughput at 4-clk spacing
    do_reset();
    sel = 8'd0; snap = act_cnt;
    for (int i = 0; i < 16; i++) send(i + 1, 4);
    repeat (10) @(negedge clk);
    chk("thru_ch0", 32'(act_cnt - snap), 16);
    chk("thru_ch0_val", 32'(o_out), 16);
    do_reset();
    sel = 8'd4; snap = act_cnt;
    for (int i = 0; i < 16; i++) send($urandom_range(0, 255), 4);
    repeat (10) @(negedge clk);
    chk("thru_ch4", 32'(act_cnt - snap), 1);
    chk("thru_ch4_val", 32'(o_out), 32'(exp_out()));

    // pin edge to ch0 output latency
    sel = 8'd0;
    send(8'h5A, 10);
    @(negedge clk);
    i_value = 8'hA5;
    i_data_clk = 1'b1;
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (n == 0 && o_out == 8'hA5) n = i;
      if (i == 3) i_data_clk = 1'b0;
    end
    chk("latency", 32'(n), 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
